uart_modport: RTL and testbench
===============================

UART_MODPORT -- requirements
Module: uart_modport

Interface
REQ-001 No parameters; the block is a fixed 8-bit Wishbone-slave UART with 8N1 framing.
REQ-002 wb_clk_i  in  1  the single system clock; all logic SHALL be on its rising edge.
REQ-003 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-004 wb_adr_i  in  3  register address.
REQ-005 wb_dat_i  in  8  write data.
REQ-006 wb_dat_o  out 8  read data, registered.
REQ-007 wb_sel_i  in  4  byte select; SHALL be ignored.
REQ-008 wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
REQ-009 wb_ack_o  out 1  Wishbone acknowledge.
REQ-010 int_o  out 1  interrupt request, active-high.
REQ-011 stx_pad_o  out 1  serial TX line, idle high.
REQ-012 srx_pad_i  in  1  serial RX line, synchronised internally through 2 flops.

Function
REQ-013 Handshake: wb_ack_o SHALL be set to stb&cyc&~ack every clock.
  - Result: a one-cycle pulse one clock after the request.
  - A held strobe gives an ack every other clock.
REQ-014 Register access and wb_dat_o update SHALL occur only in the cycle where wb_ack_o is registered high; all side effects SHALL happen once per ack.
REQ-015 Register map (DLAB = LCR[7]):
  - 0: RBR (read) / THR (write), or DLL when DLAB=1.
  - 1: IER[2:0], or DLM when DLAB=1.
  - 2: IIR (read); writes ignored.
  - 3: LCR, R/W 8 bits.
  - 4: MCR[4:0], R/W storage only.
  - 5: LSR, read-only.
  - 6: MSR, reads 0x00.
  - 7: SCR, R/W 8 bits.
  - Unused read bits SHALL be 0.
REQ-016 Baud tick: a 16-bit counter SHALL count to {DLM,DLL}-1 and emit a one-clock tick (16x oversample).
  - Divisor 0: no ticks.
  - Divisor write: counter reloads to 0.
REQ-017 TX frame: start 0, 8 data bits LSB first, stop 1; each bit SHALL last 16 ticks.
REQ-018 THR write SHALL load the holding register and clear LSR[5] THRE.
  - Idle shifter: SHALL take the byte on the next tick and set THRE again.
  - Write while THRE=0: SHALL overwrite the holding byte.
REQ-019 LSR[6] TEMT SHALL be 1 only when the holding register is empty and the shifter is idle.
REQ-020 RX start detection: a synchronised falling edge starts a frame; the start bit SHALL be rechecked after 8 ticks.
  - Still high: ignore as a glitch, return to idle.
  - Otherwise: sample data every 16 ticks, then the stop bit.
REQ-021 At the stop sample the byte SHALL be written to RBR and LSR[0] DR set.
  - Stop bit = 0: LSR[3] FE set.
  - DR already 1: LSR[1] OE set and RBR overwritten.
REQ-022 Reading RBR SHALL clear DR; reading LSR SHALL clear OE and FE.
  - A clear that coincides with a new set: the set SHALL win.
REQ-023 LSR[7,4,2] SHALL read 0.
REQ-024 IIR priority, highest first:
  - Line status (IER[2] & (OE|FE)) = 0x06.
  - RX data (IER[0] & DR) = 0x04.
  - THR empty (IER[1] & THRE & thre_pend) = 0x02.
  - None = 0x01.
REQ-025 thre_pend SHALL set on each THRE 0->1 transition and on writing IER[1] 0->1 while THRE=1.
  - It SHALL clear on a THR write, or on an IIR read returning 0x02.
REQ-026 int_o SHALL equal ~IIR[0], registered.
REQ-027 RX and TX state machines SHALL run independently; a bus access SHALL never stall them.

Reset
REQ-028 While wb_rst_i=1, all state SHALL clear asynchronously to these values:
  - wb_ack_o=0, wb_dat_o=0x00, int_o=0, stx_pad_o=1.
  - IER=0, LCR=0x03, MCR=0, SCR=0, DLL=DLM=0.
  - LSR=0x60, IIR=0x01, thre_pend=0.
  - RX and TX state machines in idle.
REQ-029 Reset asserted mid-frame SHALL abort the frame; stx_pad_o SHALL go high immediately.

Verification
REQ-030 Reset, then read addresses 0-7 -> wb_ack_o pulses once per read; LSR=0x60, IIR=0x01, LCR=0x03; int_o=0.
REQ-031 LCR=0x83, DLL=0x01, DLM=0x00, LCR=0x03; SCR=0x5A; read SCR -> 0x5A; read addr 0 with DLAB=1 -> 0x01.
REQ-032 Divisor 1, write THR=0xA5 -> stx_pad_o shows 0,1,0,1,0,0,1,0,1,1, each for 16 clocks; then LSR=0x60.
REQ-033 Divisor 1, drive 0x3C 8N1 on srx_pad_i -> LSR=0x61, RBR=0x3C, then LSR=0x60 after the RBR read.
  - Overrun case: a second frame with no RBR read -> LSR[1]=1, cleared by an LSR read.
REQ-034 IER=0x07, drive a frame with stop bit 0 -> IIR=0x06, int_o=1; LSR read -> IIR=0x04; RBR read -> IIR=0x02.
REQ-035 THRE interrupt: IIR read returns 0x02 -> next IIR read returns 0x01 and int_o=0.

Source files
------------

// File: rtl/uart_modport.sv
// Wishbone-slave UART with a fixed 8N1 frame, a 16x oversampling baud tick
// taken from the {DLM,DLL} divisor, and one holding register on each direction.
module uart_modport (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic [3:0] wb_sel_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    output logic       int_o,
    output logic       stx_pad_o,
    input  logic       srx_pad_i
);

    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]  lcr_r, dll_r, dlm_r, scr_r, rbr_r, thr_r;
    logic [2:0]  ier_r;
    logic [4:0]  mcr_r;
    logic        dr_r, oe_r, fe_r, thre_pend_r, thr_full_r;
    logic [15:0] baud_cnt_r;
    tx_state_t   tx_state_r;
    logic [9:0]  tx_sh_r;
    logic [3:0]  tx_bit_r, tx_tcnt_r;
    rx_state_t   rx_state_r;
    logic        rx_sync1_r, rx_sync2_r, rx_prev_r;
    logic [3:0]  rx_tcnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_sh_r;

    logic        acc_s, wr_s, rd_s, dlab_s, tick_s, thre_s, temt_s;
    logic        thr_wr_s, div_wr_s, rbr_rd_s, lsr_rd_s, tx_load_s, rx_stop_s;
    logic        ier1_rise_s, iir_clr_s;
    logic [15:0] div_s;
    logic [7:0]  lsr_s, iir_s, rdata_s;
    logic        unused_sel_s;

    assign unused_sel_s = ^wb_sel_i;

    // One access per ack: the request is taken on the edge that raises ack.
    assign acc_s    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_s     = acc_s & wb_we_i;
    assign rd_s     = acc_s & ~wb_we_i;
    assign dlab_s   = lcr_r[7];
    assign thr_wr_s = wr_s & ~dlab_s & (wb_adr_i == 3'd0);
    assign div_wr_s = wr_s & dlab_s & (wb_adr_i[2:1] == 2'b00);
    assign rbr_rd_s = rd_s & ~dlab_s & (wb_adr_i == 3'd0);
    assign lsr_rd_s = rd_s & (wb_adr_i == 3'd5);

    assign div_s     = {dlm_r, dll_r};
    assign tick_s    = (div_s != 16'd0) && (baud_cnt_r == (div_s - 16'd1));
    assign tx_load_s = tick_s & (tx_state_r == TX_IDLE) & thr_full_r;
    assign rx_stop_s = tick_s & (rx_state_r == RX_STOP) & (rx_tcnt_r == 4'd15);

    assign thre_s      = ~thr_full_r;
    assign temt_s      = thre_s & (tx_state_r == TX_IDLE);
    assign lsr_s       = {1'b0, temt_s, thre_s, 1'b0, fe_r, 1'b0, oe_r, dr_r};
    assign ier1_rise_s = wr_s & ~dlab_s & (wb_adr_i == 3'd1) & wb_dat_i[1] & ~ier_r[1] & thre_s;
    assign iir_clr_s   = rd_s & (wb_adr_i == 3'd2) & (iir_s == 8'h02);

    // Interrupt identification, highest priority first.
    always_comb begin
        iir_s = 8'h01;
        if (ier_r[2] & (oe_r | fe_r)) begin
            iir_s = 8'h06;
        end else if (ier_r[0] & dr_r) begin
            iir_s = 8'h04;
        end else if (ier_r[1] & thre_s & thre_pend_r) begin
            iir_s = 8'h02;
        end else begin
            iir_s = 8'h01;
        end
    end

    // Read data mux for the register map.
    always_comb begin
        rdata_s = 8'h00;
        case (wb_adr_i)
            3'd0:    rdata_s = dlab_s ? dll_r : rbr_r;
            3'd1:    rdata_s = dlab_s ? dlm_r : {5'd0, ier_r};
            3'd2:    rdata_s = iir_s;
            3'd3:    rdata_s = lcr_r;
            3'd4:    rdata_s = {3'd0, mcr_r};
            3'd5:    rdata_s = lsr_s;
            3'd6:    rdata_s = 8'h00;
            3'd7:    rdata_s = scr_r;
            default: rdata_s = 8'h00;
        endcase
    end

    // Bus handshake, control registers, receive status and interrupt state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= 8'h00;
            int_o       <= 1'b0;
            lcr_r       <= 8'h03;
            dll_r       <= 8'h00;
            dlm_r       <= 8'h00;
            scr_r       <= 8'h00;
            rbr_r       <= 8'h00;
            ier_r       <= 3'd0;
            mcr_r       <= 5'd0;
            dr_r        <= 1'b0;
            oe_r        <= 1'b0;
            fe_r        <= 1'b0;
            thre_pend_r <= 1'b0;
        end else begin
            wb_ack_o <= acc_s;
            int_o    <= ~iir_s[0];
            if (rd_s) wb_dat_o <= rdata_s;
            if (wr_s) begin
                case (wb_adr_i)
                    3'd0:    if (dlab_s) dll_r <= wb_dat_i;
                    3'd1:    if (dlab_s) dlm_r <= wb_dat_i; else ier_r <= wb_dat_i[2:0];
                    3'd3:    lcr_r <= wb_dat_i;
                    3'd4:    mcr_r <= wb_dat_i[4:0];
                    3'd7:    scr_r <= wb_dat_i;
                    default: ;
                endcase
            end
            if (rx_stop_s) rbr_r <= rx_sh_r;
            // A new received frame wins over a clear in the same cycle.
            if (rx_stop_s) dr_r <= 1'b1; else if (rbr_rd_s) dr_r <= 1'b0;
            if (rx_stop_s & dr_r) oe_r <= 1'b1; else if (lsr_rd_s) oe_r <= 1'b0;
            if (rx_stop_s & ~rx_sync2_r) fe_r <= 1'b1; else if (lsr_rd_s) fe_r <= 1'b0;
            if ((tx_load_s & ~thr_wr_s) | ier1_rise_s) thre_pend_r <= 1'b1;
            else if (thr_wr_s | iir_clr_s) thre_pend_r <= 1'b0;
        end
    end

    // Baud divisor counter producing the 16x oversampling tick.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            baud_cnt_r <= 16'd0;
        end else if (div_wr_s || (div_s == 16'd0) || tick_s) begin
            baud_cnt_r <= 16'd0;
        end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
        end
    end

    // Transmit holding register and shifter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_state_r <= TX_IDLE;
            tx_sh_r    <= 10'h3FF;
            tx_bit_r   <= 4'd0;
            tx_tcnt_r  <= 4'd0;
            stx_pad_o  <= 1'b1;
            thr_r      <= 8'h00;
            thr_full_r <= 1'b0;
        end else begin
            if (thr_wr_s) begin
                thr_r      <= wb_dat_i;
                thr_full_r <= 1'b1;
            end else if (tx_load_s) begin
                thr_full_r <= 1'b0;
            end
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_load_s) begin
                        tx_sh_r    <= {1'b1, thr_r, 1'b0};
                        stx_pad_o  <= 1'b0;
                        tx_bit_r   <= 4'd0;
                        tx_tcnt_r  <= 4'd0;
                        tx_state_r <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tick_s) begin
                        if (tx_tcnt_r == 4'd15) begin
                            tx_tcnt_r <= 4'd0;
                            if (tx_bit_r == 4'd9) begin
                                tx_state_r <= TX_IDLE;
                                stx_pad_o  <= 1'b1;
                            end else begin
                                tx_bit_r  <= tx_bit_r + 4'd1;
                                stx_pad_o <= tx_sh_r[1];
                                tx_sh_r   <= {1'b1, tx_sh_r[9:1]};
                            end
                        end else begin
                            tx_tcnt_r <= tx_tcnt_r + 4'd1;
                        end
                    end
                end
                default: tx_state_r <= TX_IDLE;
            endcase
        end
    end

    // Receive synchroniser and frame sampler.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_tcnt_r  <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_sh_r    <= 8'h00;
        end else begin
            rx_sync1_r <= srx_pad_i;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r & ~rx_sync2_r) begin
                        rx_state_r <= RX_START;
                        rx_tcnt_r  <= 4'd0;
                    end
                end
                RX_START: begin
                    if (tick_s) begin
                        if (rx_tcnt_r == 4'd7) begin
                            // Mid-start-bit recheck rejects glitches.
                            rx_tcnt_r  <= 4'd0;
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= rx_sync2_r ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_s) begin
                        if (rx_tcnt_r == 4'd15) begin
                            rx_tcnt_r <= 4'd0;
                            rx_sh_r   <= {rx_sync2_r, rx_sh_r[7:1]};
                            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                            else rx_bit_r <= rx_bit_r + 3'd1;
                        end else begin
                            rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick_s) begin
                        if (rx_tcnt_r == 4'd15) begin
                            rx_tcnt_r  <= 4'd0;
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        end
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_modport.sv
// Directed-plus-random bench for uart_modport; expectations come from a
// register-level model of the UART and from frame-level TX/RX line models.
module tb_uart_modport;

    logic       clk, rst;
    logic [2:0] adr;
    logic [7:0] dat_i, dat_o;
    logic [3:0] sel;
    logic       stb, cyc, we, ack, irq, stx, srx;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lcr, m_dll, m_dlm, m_scr, m_rbr;
    logic [2:0] m_ier;
    logic [4:0] m_mcr;
    bit         m_dr, m_oe, m_fe, m_pend, m_thre, m_temt;

    logic       tx_log;
    logic       tx_log_q[$];
    logic [7:0] tx_exp_q[$];

    uart_modport dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_we_i  (we),
        .wb_ack_o (ack),
        .int_o    (irq),
        .stx_pad_o(stx),
        .srx_pad_i(srx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the TX line once per clock while a transmit test is running.
    always @(posedge clk) begin
        #1;
        if (tx_log) tx_log_q.push_back(stx);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lcr = 8'h03; m_dll = 8'h00; m_dlm = 8'h00; m_scr = 8'h00; m_rbr = 8'h00;
        m_ier = 3'd0; m_mcr = 5'd0;
        m_dr = 1'b0; m_oe = 1'b0; m_fe = 1'b0; m_pend = 1'b0; m_thre = 1'b1; m_temt = 1'b1;
    endtask

    function automatic logic [7:0] m_iir();
        if (m_ier[2] && (m_oe || m_fe)) return 8'h06;
        if (m_ier[0] && m_dr) return 8'h04;
        if (m_ier[1] && m_thre && m_pend) return 8'h02;
        return 8'h01;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_lcr[7] ? m_dll : m_rbr;
            3'd1:    return m_lcr[7] ? m_dlm : {5'd0, m_ier};
            3'd2:    return m_iir();
            3'd3:    return m_lcr;
            3'd4:    return {3'd0, m_mcr};
            3'd5:    return {1'b0, m_temt, m_thre, 1'b0, m_fe, 1'b0, m_oe, m_dr};
            3'd7:    return m_scr;
            default: return 8'h00;
        endcase
    endfunction

    task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] q);
        logic got;
        @(negedge clk);
        adr = a; dat_i = d; we = w; stb = 1'b1; cyc = 1'b1; sel = 4'($urandom);
        got = 1'b0;
        q = 8'h00;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                got = 1'b1;
                q = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("ack_seen", {7'd0, got}, 8'd1);
        @(posedge clk); #1;
        chk("ack_single", {7'd0, ack}, 8'd0);
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        logic [7:0] e, q;
        e = m_read(a);
        bus(1'b0, a, 8'h00, q);
        chk(tag, q, e);
        if (a == 3'd0 && !m_lcr[7]) m_dr = 1'b0;
        if (a == 3'd5) begin m_oe = 1'b0; m_fe = 1'b0; end
        if (a == 3'd2 && e == 8'h02) m_pend = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(1'b1, a, d, q);
        case (a)
            3'd0: if (m_lcr[7]) m_dll = d;
                  else begin m_thre = 1'b0; m_temt = 1'b0; m_pend = 1'b0; tx_exp_q.push_back(d); end
            3'd1: if (m_lcr[7]) m_dlm = d;
                  else begin
                      if (d[1] && !m_ier[1] && m_thre) m_pend = 1'b1;
                      m_ier = d[2:0];
                  end
            3'd3: m_lcr = d;
            3'd4: m_mcr = d[4:0];
            3'd7: m_scr = d;
            default: ;
        endcase
    endtask

    // The shifter has taken the holding byte: THRE returns and raises pending.
    task automatic tx_loaded();
        m_thre = 1'b1;
        m_pend = 1'b1;
    endtask

    // Drive one 8N1 frame at 16 clocks per bit; model the receiver's effect.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            srx = f[i];
            repeat (16) @(negedge clk);
        end
        srx = 1'b1;
        repeat (10) @(negedge clk);
        if (m_dr) m_oe = 1'b1;
        m_rbr = b;
        m_dr  = 1'b1;
        if (!stop) m_fe = 1'b1;
    endtask

    initial begin
        logic [7:0] b, b1, b2;
        logic [9:0] f;
        int         j;
        bit         ok;

        rst = 1'b1; adr = 3'd0; dat_i = 8'h00; sel = 4'd0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; srx = 1'b1; tx_log = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_stx", {7'd0, stx}, 8'd1);
        chk("rst_ack", {7'd0, ack}, 8'd0);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_int", {7'd0, irq}, 8'd0);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("rst_rd%0d", a));
        chk("rst_int_after", {7'd0, irq}, 8'd0);

        // Divisor 1, scratch, modem control and DLAB readback
        wr(3'd3, 8'h83); wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd3, 8'h03);
        b = 8'($urandom);
        wr(3'd7, b); rd(3'd7, "scr");
        wr(3'd7, 8'h5A); rd(3'd7, "scr_5a");
        wr(3'd4, 8'($urandom)); rd(3'd4, "mcr");
        wr(3'd3, 8'h83); rd(3'd0, "dll"); rd(3'd1, "dlm"); wr(3'd3, 8'h03);
        rd(3'd1, "ier0");

        // TX: single 0xA5 frame, then two random bytes back to back
        tx_log = 1'b1;
        wr(3'd0, 8'hA5); tx_loaded();
        repeat (175) @(negedge clk);
        m_temt = 1'b1;
        rd(3'd5, "lsr_tx_done");
        b1 = 8'($urandom); b2 = 8'($urandom);
        wr(3'd0, b1); tx_loaded();
        wr(3'd0, b2);
        rd(3'd5, "lsr_tx_busy");
        repeat (345) @(negedge clk);
        tx_loaded(); m_temt = 1'b1;
        rd(3'd5, "lsr_tx_done2");
        tx_log = 1'b0;

        j = 0;
        foreach (tx_exp_q[k]) begin
            f = {1'b1, tx_exp_q[k], 1'b0};
            while (j < tx_log_q.size() && tx_log_q[j] !== 1'b0) j++;
            ok = (j + 160 <= tx_log_q.size());
            for (int bi = 0; bi < 10 && ok; bi++)
                for (int c = 0; c < 16; c++)
                    if (tx_log_q[j + 16 * bi + c] !== f[bi]) ok = 1'b0;
            chk($sformatf("tx_frame%0d", k), {7'd0, ok}, 8'd1);
            j += 160;
        end
        ok = 1'b1;
        for (int i = j; i < tx_log_q.size(); i++) if (tx_log_q[i] !== 1'b1) ok = 1'b0;
        chk("tx_tail_idle", {7'd0, ok}, 8'd1);

        // RX: 0x3C, random frames, overrun, glitch
        send_rx(8'h3C, 1'b1);
        rd(3'd5, "lsr_rx"); rd(3'd0, "rbr_3c"); rd(3'd5, "lsr_rx_clr");
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            rd(3'd0, "rbr_rand"); rd(3'd5, "lsr_rand");
        end
        b1 = 8'($urandom); b2 = 8'($urandom);
        send_rx(b1, 1'b1); send_rx(b2, 1'b1);
        rd(3'd5, "lsr_oe"); rd(3'd5, "lsr_oe_clr"); rd(3'd0, "rbr_oe"); rd(3'd5, "lsr_oe_end");
        srx = 1'b0;
        repeat (3) @(negedge clk);
        srx = 1'b1;
        repeat (40) @(negedge clk);
        rd(3'd5, "lsr_glitch");

        // Interrupt priority chain
        wr(3'd1, 8'h07);
        b = 8'($urandom);
        send_rx(b, 1'b0);
        chk("int_fe", {7'd0, irq}, 8'd1);
        rd(3'd2, "iir_ls"); rd(3'd5, "lsr_fe"); rd(3'd2, "iir_rx");
        rd(3'd0, "rbr_fe"); rd(3'd2, "iir_thre"); rd(3'd2, "iir_none");
        chk("int_clear", {7'd0, irq}, 8'd0);

        // Reset in the middle of a transmitted frame
        wr(3'd0, 8'($urandom));
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_stx", {7'd0, stx}, 8'd1);
        chk("midrst_ack", {7'd0, ack}, 8'd0);
        chk("midrst_int", {7'd0, irq}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd(3'd5, "lsr_post_rst"); rd(3'd3, "lcr_post_rst"); rd(3'd2, "iir_post_rst");
        chk("stx_post_rst", {7'd0, stx}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
